// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer driving a one-bit ALU slice LSB first, WIDTH cycles per operation.
// Optional `SERIAL_OVF_EN adds o_ovf (two's-complement overflow of the MSB step).
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [3:0]       o_sl_op,
    output logic             o_sl_a,
    output logic             o_sl_b,
    output logic             o_sl_cin,
    input  logic             i_sl_res,
    input  logic             i_sl_cout,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
`ifdef SERIAL_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic [3:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_res_full;

    assign w_res_full = {i_sl_res, r_res_sh};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Abort wins over the final step, so an aborted op never completes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_op     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_cout   <= 1'b0;
            o_zero   <= 1'b0;
`ifdef SERIAL_OVF_EN
            o_ovf    <= 1'b0;
`endif
        end else begin
            o_busy <= (w_state_nxt != S_IDLE);
            o_done <= w_last;
            if (w_load) begin
                r_a_sh   <= i_a;
                r_b_sh   <= i_b;
                r_res_sh <= '0;
                r_op     <= i_op;
                r_carry  <= i_cin;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_res_sh <= w_res_full[WIDTH-1:1];
                r_carry  <= i_sl_cout;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                o_result <= w_res_full;
                o_cout   <= i_sl_cout;
                o_zero   <= (w_res_full == '0);
`ifdef SERIAL_OVF_EN
                o_ovf    <= r_carry ^ i_sl_cout;
`endif
            end
        end
    end

    assign o_sl_op  = r_op;
    assign o_sl_a   = r_a_sh[0];
    assign o_sl_b   = r_b_sh[0];
    assign o_sl_cin = r_carry;

endmodule
